axi_lite_mem_slave: RTL
=======================

# axi_lite_mem_slave

AXI4-Lite slave memory endpoint that terminates the AXI master port of the Wishbone-to-AXI bridge in block_3 and stands in for the downstream peripheral. It accepts independent write-address and write-data channels, performs byte-strobed writes into a word-addressed register file, and returns buffered B and R responses under full valid/ready back-pressure. It is the synthesizable counterpart the `axi_slave_BFM` agent is checked against.

## Interface
- ADDR_W, 12, AXI byte-address width
- DATA_W, 32, data width; fixed at 32; strobe width is DATA_W/8
- DEPTH, 256, number of 32-bit words; must be ≤ 2^(ADDR_W-2)
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- awaddr  in  ADDR_W  write byte address
- awvalid / awready  in / out  1  AW handshake
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte enables
- wvalid / wready  in / out  1  W handshake
- bresp  out  2  write response (00 OKAY, 10 SLVERR)
- bvalid / bready  out / in  1  B handshake
- araddr  in  ADDR_W  read byte address
- arvalid / arready  in / out  1  AR handshake
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- rvalid / rready  out / in  1  R handshake

## Operation
- Word index = addr[ADDR_W-1:2]; addr[1:0] ignored (no misalignment error).
- Write path: one holding register each for AW (aw_full) and W (w_full), filled independently on handshake; awready = !aw_full, wready = !w_full.
- Commit when aw_full && w_full && (!bvalid || bready): bytes with wstrb=1 written; aw_full, w_full cleared; bvalid set next cycle with bresp.
- Commit and a new AW/W handshake cannot occur in the same cycle (ready is low while full).
- Read FSM: R_IDLE, R_DATA. arready = (state==R_IDLE). On AR handshake: memory word registered into rdata, rresp computed, go R_DATA (rvalid=1). On rvalid && rready: go R_IDLE.
- rdata/rresp and bresp held stable while their valid is high and ready low.
- Same-cycle AR handshake and write commit to same word: read returns pre-write data.
- Read and write paths fully independent; no ordering between them.
- wstrb=0 commit: no bytes change, response still issued.

## Timing
- Reset (rst high at an edge): aw_full, w_full, bvalid, rvalid cleared, FSM → R_IDLE; awready, wready, arready forced 0 while rst is high; bresp, rresp, rdata = 0. Memory contents not reset.
- Reset mid-transaction discards any held AW/W and pending B/R; no partial write.
- Write latency: AW+W handshake cycle N → commit N+1 → bvalid N+2. Sustained throughput with bready=1: one write per 2 cycles.
- Read latency: AR handshake cycle N → rvalid N+1. Sustained throughput with rready=1: one read per 2 cycles.
- AW before W (or vice versa) by any number of cycles: commit the cycle after the later handshake.

## Configuration
- AXI_LITE_MEM_ERR_EN defined: index ≥ DEPTH on write → no memory update, bresp=SLVERR; on read → rdata=0, rresp=SLVERR.
- Not defined: index taken modulo DEPTH (upper bits dropped when DEPTH is a power of two, else index % DEPTH); bresp/rresp always OKAY.

## Test plan
- Reset, then AW 0x010 + W 0xDEADBEEF strobe 0xF same cycle, bready=1 → bvalid two cycles later, bresp=00; read 0x010 → rdata 0xDEADBEEF one cycle after AR, rresp=00.
- W issued 5 cycles before AW (addr 0x020, data 0x11223344) → awready/wready drop after own handshake; bvalid exactly 2 cycles after AW handshake.
- Strobe 0x5 write of 0xAABBCCDD over 0x00000000 at 0x030 → read returns 0x00BB00DD.
- bready held low 10 cycles after write, second AW/W presented → second commit stalls, bresp/bvalid stable; releases one cycle after bready.
- Write 0x400 (DEPTH=256): with AXI_LITE_MEM_ERR_EN → bresp=10, word 0 unchanged, read 0x400 → rresp=10, rdata=0; without → word 0 written, OKAY.
- rst asserted the cycle after AW handshake with W pending → after reset no write occurs, bvalid=0, all readies high.

Source files
------------

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave with independent AW/W holding registers and a byte-strobed word register file.
// Optional: define AXI_LITE_MEM_ERR_EN to return SLVERR for indices >= DEPTH instead of wrapping.
module axi_lite_mem_slave #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wvalid,
   output logic                wready,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic                arvalid,
   output logic                arready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rvalid,
   input  logic                rready
);
   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WIDX_W = ADDR_W - 2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              aw_full_q, aw_full_d;
   logic [WIDX_W-1:0] awidx_q, awidx_d;
   logic              w_full_q, w_full_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   r_state_e          state_q, state_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;

   logic              aw_hs, w_hs, ar_hs, commit, mem_we;
   logic              wr_err, rd_err;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic              unused_addr_lsbs;

   function automatic logic [IDX_W-1:0] map_idx(input logic [WIDX_W-1:0] widx);
      return IDX_W'(32'(widx) % 32'(DEPTH));
   endfunction

   assign awready = !rst && !aw_full_q;
   assign wready  = !rst && !w_full_q;
   assign arready = !rst && (state_q == R_IDLE);
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign rvalid  = (state_q == R_DATA);
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

   assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

   always_comb begin
      aw_hs  = awvalid && awready;
      w_hs   = wvalid && wready;
      ar_hs  = arvalid && arready;
      wr_idx = map_idx(awidx_q);
      rd_idx = map_idx(araddr[ADDR_W-1:2]);
`ifdef AXI_LITE_MEM_ERR_EN
      wr_err = 32'(awidx_q) >= 32'(DEPTH);
      rd_err = 32'(araddr[ADDR_W-1:2]) >= 32'(DEPTH);
`else
      wr_err = 1'b0;
      rd_err = 1'b0;
`endif
      // Reset wins over a pending commit so a held AW/W never lands half-applied.
      commit = aw_full_q && w_full_q && (!bvalid_q || bready) && !rst;
      mem_we = commit && !wr_err;
   end

   always_comb begin
      aw_full_d = aw_full_q;
      awidx_d   = awidx_q;
      w_full_d  = w_full_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      if (aw_hs) begin
         aw_full_d = 1'b1;
         awidx_d   = awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         wdata_d  = wdata;
         wstrb_d  = wstrb;
      end
      if (commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bready) begin
         bvalid_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      case (state_q)
         R_IDLE: begin
            if (ar_hs) begin
               state_d = R_DATA;
               rdata_d = rd_err ? '0 : mem[rd_idx];
               rresp_d = rd_err ? RESP_SLVERR : RESP_OKAY;
            end
         end
         R_DATA: begin
            if (rready) state_d = R_IDLE;
         end
         default: state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         state_q   <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         aw_full_q <= aw_full_d;
         w_full_q  <= w_full_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         state_q   <= state_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   always_ff @(posedge clk) begin
      awidx_q <= awidx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
   end

   // Non-blocking update means a same-cycle read of this word still sees the old data.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) mem[wr_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
         end
      end
   end
endmodule
